// File: rtl/regfile_mp_sb_if.sv
// Register file bus bundle: read ports, write ports, scoreboard set, bulk-clear control.
// The slave modport is the register file; the master modport is the pipeline driving it.
interface regfile_mp_sb_if #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = $clog2(DEPTH);

    // Handshake contract: there is no valid/ready pair on this bus.
    // - Reads are unconditional and combinational.
    // - A write, scoreboard set or clear request is taken at the rising edge where its
    //   enable is high.
    // - While clr_busy is high, writes, sets and clear requests are dropped, not held.
    logic [NUM_RD*AW-1:0]   rs_addr;
    logic [NUM_RD*XLEN-1:0] rs_data;
    logic [NUM_RD-1:0]      rs_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   sb_set_en;
    logic [AW-1:0]          sb_set_addr;
    logic                   clr_req;
    logic                   clr_busy;
    logic                   dbg_state;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
        input  rs_data, rs_busy, clr_busy, dbg_state
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
        output rs_data, rs_busy, clr_busy, dbg_state
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with busy scoreboard and sequential bulk clear; x0 reads as zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.clr_req) state_nx = CLEAR;
            CLEAR:   if (cnt == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The clear flag comes straight from the state flop, so it is registered.
    assign bus.clr_busy  = (state == CLEAR);
    assign bus.dbg_state = state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
            cnt  <= '0;
        end else if (state == IDLE) begin
            // Ascending port order lets the highest-index port win on a shared address.
            for (int p = 0; p < NUM_WR; p++) begin
                if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] != '0) begin
                    mem[bus.wr_addr[p*AW +: AW]]  <= bus.wr_data[p*XLEN +: XLEN];
                    busy[bus.wr_addr[p*AW +: AW]] <= 1'b0;
                end
            end
            if (bus.sb_set_en && bus.sb_set_addr != '0)
                busy[bus.sb_set_addr] <= 1'b1;
            if (bus.clr_req) begin
                busy <= '0;
                cnt  <= AW'(1);
            end
        end else begin
            mem[cnt] <= '0;
            if (cnt != LAST) cnt <= cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;

        assign rd_addr = bus.rs_addr[k*AW +: AW];

        always_comb begin
            rd_data = (rd_addr == '0) ? '0 : mem[rd_addr];
            rd_busy = (rd_addr == '0) ? 1'b0 : busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (state == IDLE && rd_addr != '0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] == rd_addr) begin
                        rd_data = bus.wr_data[p*XLEN +: XLEN];
                        rd_busy = bus.sb_set_en && (bus.sb_set_addr == rd_addr);
                    end
                end
            end
`endif
        end

        assign bus.rs_data[k*XLEN +: XLEN] = rd_data;
        assign bus.rs_busy[k]              = rd_busy;
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, writes, conflicts, scoreboard, bulk clear, bypass.
module tb_regfile_mp_sb;
    localparam int XLEN = 32;
    localparam int DEPTH = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic i_clk;
    logic i_reset;
    int   total = 0;
    int   bad = 0;
    int   n;

    regfile_mp_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) rf_if ();

    regfile_mp_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (rf_if.slave)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rf_if.rs_addr = {a1, a0};
        #1;
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        rf_if.wr_en   = en;
        rf_if.wr_addr = {a1, a0};
        rf_if.wr_data = {d1, d0};
    endtask

    task automatic idle();
        rf_if.wr_en     = '0;
        rf_if.sb_set_en = 1'b0;
        rf_if.clr_req   = 1'b0;
    endtask

    initial begin
        i_reset            = 1'b1;
        rf_if.rs_addr      = '0;
        rf_if.wr_en        = '0;
        rf_if.wr_addr      = '0;
        rf_if.wr_data      = '0;
        rf_if.sb_set_en    = 1'b0;
        rf_if.sb_set_addr  = '0;
        rf_if.clr_req      = 1'b0;
        #12 i_reset = 1'b0;

        // 1: reset state
        chk("rst_clr_busy", {31'd0, rf_if.clr_busy}, 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd(5'(a), 5'(DEPTH - 1 - a));
            chk($sformatf("rst_d0_x%0d", a), rf_if.rs_data[31:0], 32'd0);
            chk($sformatf("rst_d1_x%0d", a), rf_if.rs_data[63:32], 32'd0);
            chk($sformatf("rst_busy_x%0d", a), {30'd0, rf_if.rs_busy}, 32'd0);
        end

        // 2: write x5 and x0
        step();
        wr(2'b11, 5'd5, 32'hDEADBEEF, 5'd0, 32'h1234);
        step();
        idle();
        rd(5'd5, 5'd0);
        chk("wr_x5", rf_if.rs_data[31:0], 32'hDEADBEEF);
        chk("wr_x0", rf_if.rs_data[63:32], 32'd0);

        // 3: same-address conflict, port 1 wins
        wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        step();
        idle();
        rd(5'd7, 5'd7);
        chk("conflict_x7", rf_if.rs_data[31:0], 32'h22);

        // 4: scoreboard set, then write clears
        rf_if.sb_set_en = 1'b1;
        rf_if.sb_set_addr = 5'd9;
        step();
        idle();
        step();
        step();
        rd(5'd9, 5'd0);
        chk("sb_set_x9", {31'd0, rf_if.rs_busy[0]}, 32'd1);
        chk("sb_x0_busy", {31'd0, rf_if.rs_busy[1]}, 32'd0);
        wr(2'b01, 5'd9, 32'h5, 5'd0, 32'h0);
        step();
        idle();
        rd(5'd9, 5'd0);
        chk("sb_wrclr_x9", {31'd0, rf_if.rs_busy[0]}, 32'd0);
        chk("sb_wrdata_x9", rf_if.rs_data[31:0], 32'h5);

        // 5: set and write on the same register, set wins
        rf_if.sb_set_en = 1'b1;
        rf_if.sb_set_addr = 5'd9;
        wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h6);
        step();
        idle();
        rd(5'd9, 5'd0);
        chk("sb_setwins_x9", {31'd0, rf_if.rs_busy[0]}, 32'd1);
        chk("sb_setwins_data", rf_if.rs_data[31:0], 32'h6);

        // 6: fill, bulk clear, ignored write/set mid-clear
        for (int a = 1; a < DEPTH; a++) begin
            wr(2'b01, 5'(a), 32'h100 + a, 5'd0, 32'h0);
            step();
        end
        idle();
        rd(5'd31, 5'd1);
        chk("fill_x31", rf_if.rs_data[31:0], 32'h11F);
        chk("fill_x1", rf_if.rs_data[63:32], 32'h101);
        rf_if.clr_req = 1'b1;
        step();
        rf_if.clr_req = 1'b0;
        chk("clr_state", {31'd0, rf_if.dbg_state}, 32'd1);
        n = 0;
        while (rf_if.clr_busy === 1'b1 && n < 100) begin
            n++;
            if (n == 2) begin
                rd(5'd1, 5'd2);
                chk("clr_part_x1", rf_if.rs_data[31:0], 32'd0);
                chk("clr_part_x2", rf_if.rs_data[63:32], 32'h102);
            end
            if (n == 5) begin
                wr(2'b01, 5'd1, 32'hFFFF, 5'd0, 32'h0);
                rf_if.sb_set_en = 1'b1;
                rf_if.sb_set_addr = 5'd12;
            end
            if (n == 6) idle();
            step();
        end
        idle();
        chk("clr_cycles", n, 32'd31);
        chk("clr_done_state", {31'd0, rf_if.dbg_state}, 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd(5'(a), 5'(a));
            chk($sformatf("clr_x%0d", a), rf_if.rs_data[31:0], 32'd0);
        end
        rd(5'd12, 5'd9);
        chk("clr_busy_x12", {31'd0, rf_if.rs_busy[0]}, 32'd0);
        chk("clr_busy_x9", {31'd0, rf_if.rs_busy[1]}, 32'd0);

        // 7: async reset mid-clear
        wr(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
        step();
        idle();
        rf_if.clr_req = 1'b1;
        step();
        rf_if.clr_req = 1'b0;
        step();
        step();
        step();
        rd(5'd4, 5'd0);
        chk("midclr_busy", {31'd0, rf_if.clr_busy}, 32'd1);
        chk("midclr_x4_kept", rf_if.rs_data[31:0], 32'h44);
        i_reset = 1'b1;
        #1;
        chk("rst_midclr_busy", {31'd0, rf_if.clr_busy}, 32'd0);
        chk("rst_midclr_x4", rf_if.rs_data[31:0], 32'd0);
        i_reset = 1'b0;
        step();
        step();
        chk("no_resume", {31'd0, rf_if.clr_busy}, 32'd0);

        // 8/9: same-cycle read of a register being written
        wr(2'b01, 5'd3, 32'h1111, 5'd0, 32'h0);
        step();
        idle();
        wr(2'b10, 5'd0, 32'h0, 5'd3, 32'hA5A5);
        rd(5'd3, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same", rf_if.rs_data[31:0], 32'hA5A5);
`else
        chk("nobypass_same", rf_if.rs_data[31:0], 32'h1111);
`endif
        step();
        idle();
        rd(5'd3, 5'd0);
        chk("bypass_next", rf_if.rs_data[31:0], 32'hA5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
